// File: rtl/glitch_sweep_sched.sv
// glitch_sweep_sched: round-robin owner of the glitch FIFO write port for 2-D sweeps and host words
module glitch_sweep_sched #(
    parameter int DELAY_W = 32,
    parameter int WIDTH_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [DELAY_W-1:0]         delay_start_i,
    input  logic [DELAY_W-1:0]         delay_step_i,
    input  logic [CNT_W-1:0]           delay_count_i,
    input  logic [WIDTH_W-1:0]         width_start_i,
    input  logic [WIDTH_W-1:0]         width_step_i,
    input  logic [CNT_W-1:0]           width_count_i,
    input  logic                       host_req_i,
    input  logic [DELAY_W+WIDTH_W-1:0] host_dat_i,
    output logic                       host_ack_o,
    input  logic                       fifo_full_i,
    output logic                       fifo_we_o,
    output logic [DELAY_W+WIDTH_W-1:0] fifo_dat_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [31:0]                issued_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [DELAY_W-1:0]         delay_step_q, delay_cur_q;
    logic [WIDTH_W-1:0]         width_start_q, width_step_q, width_cur_q;
    logic [CNT_W-1:0]           delay_count_q, width_count_q, d_idx_q, w_idx_q;
    logic [DELAY_W+WIDTH_W-1:0] fifo_dat_q;
    logic [31:0]                issued_q;
    logic fifo_we_q, host_ack_q, done_q, last_sweep_q;
    logic slot, run_ok, host_gnt, sweep_gnt, last_w, last_d, start_ok;

    // Slot/arbitration decode: a gap cycle after every write absorbs the full-flag latency
    always_comb begin
        slot      = !fifo_full_i && !fifo_we_q;
        run_ok    = state_q == RUN && !abort_i;
        start_ok  = state_q == IDLE && start_i;
        host_gnt  = slot && host_req_i && (state_q != RUN || (run_ok && last_sweep_q));
        sweep_gnt = slot && run_ok && (!host_req_i || !last_sweep_q);
        last_w    = w_idx_q == width_count_q - CNT_W'(1);
        last_d    = d_idx_q == delay_count_q - CNT_W'(1);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: empty sweeps go straight to DONE so they still produce a done pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = (delay_count_i != '0 && width_count_i != '0) ? RUN : DONE;
            RUN: begin
                if (abort_i) state_d = IDLE;
                else if (sweep_gnt && last_w && last_d) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb busy_o = state_q != IDLE;

    // Write port, sweep counters and config snapshot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_we_q     <= 1'b0;
            host_ack_q    <= 1'b0;
            done_q        <= 1'b0;
            fifo_dat_q    <= '0;
            last_sweep_q  <= 1'b0;
            issued_q      <= '0;
            delay_step_q  <= '0;
            delay_cur_q   <= '0;
            delay_count_q <= '0;
            width_start_q <= '0;
            width_step_q  <= '0;
            width_cur_q   <= '0;
            width_count_q <= '0;
            d_idx_q       <= '0;
            w_idx_q       <= '0;
        end else begin
            fifo_we_q  <= host_gnt || sweep_gnt;
            host_ack_q <= host_gnt;
            done_q     <= state_q == DONE;
            fifo_dat_q <= host_gnt ? host_dat_i : sweep_gnt ? {width_cur_q, delay_cur_q} : fifo_dat_q;
            if (host_gnt || sweep_gnt) last_sweep_q <= sweep_gnt;
            if (start_ok) begin
                delay_step_q  <= delay_step_i;
                delay_cur_q   <= delay_start_i;
                delay_count_q <= delay_count_i;
                width_start_q <= width_start_i;
                width_step_q  <= width_step_i;
                width_cur_q   <= width_start_i;
                width_count_q <= width_count_i;
                d_idx_q       <= '0;
                w_idx_q       <= '0;
                issued_q      <= '0;
            end else if (sweep_gnt) begin
                issued_q <= issued_q + 32'd1;
                if (last_w) begin
                    w_idx_q     <= '0;
                    width_cur_q <= width_start_q;
                    if (!last_d) begin
                        d_idx_q     <= d_idx_q + CNT_W'(1);
                        delay_cur_q <= delay_cur_q + delay_step_q;
                    end
                end else begin
                    w_idx_q     <= w_idx_q + CNT_W'(1);
                    width_cur_q <= width_cur_q + width_step_q;
                end
            end
        end
    end

    assign fifo_we_o  = fifo_we_q;
    assign host_ack_o = host_ack_q;
    assign fifo_dat_o = fifo_dat_q;
    assign done_o     = done_q;
    assign issued_o   = issued_q;
endmodule

// File: tb/tb_glitch_sweep_sched.sv
// tb_glitch_sweep_sched: directed checks of sweep order, full stall, host arbitration, abort, wrap, reset
module tb_glitch_sweep_sched;
    logic clk = 0, rst = 1, start = 0, abort = 0, host_req = 0, full = 0;
    logic [31:0] d_start = 0, d_step = 0, issued;
    logic [15:0] d_count = 0, w_start = 0, w_step = 0, w_count = 0;
    logic [47:0] host_dat = 0, fifo_dat;
    logic host_ack, fifo_we, busy, done;
    int checks = 0, errors = 0;
    localparam logic [47:0] HOST_W = 48'hABCD_0000_1234;

    always #5 clk = ~clk;

    glitch_sweep_sched dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .delay_start_i(d_start), .delay_step_i(d_step), .delay_count_i(d_count),
        .width_start_i(w_start), .width_step_i(w_step), .width_count_i(w_count),
        .host_req_i(host_req), .host_dat_i(host_dat), .host_ack_o(host_ack),
        .fifo_full_i(full), .fifo_we_o(fifo_we), .fifo_dat_o(fifo_dat),
        .busy_o(busy), .done_o(done), .issued_o(issued)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a write, checks data/ack, then checks the following cycle is idle
    task automatic wait_write(input string tag, input logic [47:0] dat, input logic ack);
        int n = 0;
        do begin
            step();
            n++;
        end while (!fifo_we && n < 60);
        chk({tag, "_seen"}, 64'(fifo_we), 64'd1);
        chk({tag, "_dat"}, 64'(fifo_dat), 64'(dat));
        chk({tag, "_ack"}, 64'(host_ack), 64'(ack));
        step();
        chk({tag, "_gap"}, 64'(fifo_we), 64'd0);
    endtask

    task automatic start_sweep(input logic [31:0] ds, input logic [31:0] dst, input logic [15:0] dc,
                               input logic [15:0] ws, input logic [15:0] wst, input logic [15:0] wc);
        d_start = ds; d_step = dst; d_count = dc;
        w_start = ws; w_step = wst; w_count = wc;
        start = 1;
        step();
        start = 0;
        d_start = 0; d_step = 0; d_count = 0; w_start = 0; w_step = 0; w_count = 0;
    endtask

    // Delay 100/10/3, width 5/1/2; optional full stall after word full_at, optional host word after host_at
    task automatic sweep6(input string tag, input int full_at, input int host_at);
        start_sweep(32'd100, 32'd10, 16'd3, 16'd5, 16'd1, 16'd2);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_issued0"}, 64'(issued), 64'd0);
        if (host_at >= 0) begin
            host_req = 1;
            host_dat = HOST_W;
        end
        for (int i = 0; i < 6; i++) begin
            wait_write($sformatf("%s_w%0d", tag, i), {16'(5 + i % 2), 32'(100 + 10 * (i / 2))}, 1'b0);
            if (i == full_at) begin
                full = 1;
                for (int c = 0; c < 20; c++) begin
                    step();
                    chk({tag, "_full_nowe"}, 64'(fifo_we), 64'd0);
                end
                full = 0;
            end
            if (i == host_at) begin
                wait_write({tag, "_host"}, HOST_W, 1'b1);
                host_req = 0;
                host_dat = 0;
            end
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_issued"}, 64'(issued), 64'd6);
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_issued_hold"}, 64'(issued), 64'd6);
    endtask

    initial begin
        step();
        step();
        chk("rst_we", 64'(fifo_we), 64'd0);
        chk("rst_ack", 64'(host_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_issued", 64'(issued), 64'd0);
        chk("rst_dat", 64'(fifo_dat), 64'd0);
        rst = 0;
        step();

        sweep6("t1", -1, -1);
        sweep6("t2", 1, -1);

        rst = 1;
        step();
        rst = 0;
        sweep6("t3", -1, 0);

        start_sweep(32'd100, 32'd10, 16'd3, 16'd5, 16'd1, 16'd2);
        wait_write("t4_w0", {16'd5, 32'd100}, 1'b0);
        wait_write("t4_w1", {16'd6, 32'd100}, 1'b0);
        abort = 1;
        step();
        abort = 0;
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_we", 64'(fifo_we), 64'd0);
        chk("t4_issued", 64'(issued), 64'd2);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t4_nowe", 64'(fifo_we), 64'd0);
            chk("t4_nodone", 64'(done), 64'd0);
        end
        sweep6("t4r", -1, -1);

        start_sweep(32'hFFFF_FFF0, 32'h20, 16'd2, 16'd5, 16'd1, 16'd1);
        wait_write("t5_w0", {16'd5, 32'hFFFF_FFF0}, 1'b0);
        wait_write("t5_w1", {16'd5, 32'h0000_0010}, 1'b0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_issued", 64'(issued), 64'd2);
        step();
        start_sweep(32'd1, 32'd1, 16'd4, 16'd1, 16'd1, 16'd0);
        chk("t5e_busy", 64'(busy), 64'd1);
        chk("t5e_we0", 64'(fifo_we), 64'd0);
        step();
        chk("t5e_busy_end", 64'(busy), 64'd0);
        chk("t5e_done", 64'(done), 64'd1);
        chk("t5e_we1", 64'(fifo_we), 64'd0);
        chk("t5e_issued", 64'(issued), 64'd0);
        step();
        chk("t5e_done_pulse", 64'(done), 64'd0);

        start_sweep(32'd100, 32'd10, 16'd3, 16'd5, 16'd1, 16'd2);
        step();
        chk("t6_pre_we", 64'(fifo_we), 64'd1);
        rst = 1;
        step();
        chk("t6_we", 64'(fifo_we), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_issued", 64'(issued), 64'd0);
        chk("t6_dat", 64'(fifo_dat), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        rst = 0;
        step();
        sweep6("t6r", -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
